// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver deserialising sdi into signed L/R sample pairs
//
// Ports:
//   clk        system clock; every register runs on its rising edge
//   rst        synchronous active-high reset
//   sclk       bit clock (clk domain); sdi is sampled on its rising edge
//   lrclk      word select, 0 = left, 1 = right
//   sdi        serial data from the ADC, MSB first
//   l_sample   signed left sample of the last emitted pair
//   r_sample   signed right sample of the last emitted pair
//   valid      pair available, held until ready
//   ready      consumer accepts the pair when valid & ready
//   overrun    1-cycle pulse when a new pair lands while valid & !ready
//   frame_err  1-cycle pulse on a short word (only with I2S_RX_FRAME_ERR_EN)
//
// Optional feature macro: I2S_RX_FRAME_ERR_EN adds the frame_err port.

module i2s_rx #(
    parameter int DW        = 24,
    parameter int MSB_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 lrclk,
    input  logic                 sdi,
    output logic signed [DW-1:0] l_sample,
    output logic signed [DW-1:0] r_sample,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overrun
`ifdef I2S_RX_FRAME_ERR_EN
   ,output logic                 frame_err
`endif
);

    localparam int CW = $clog2(DW + 1);

    logic          sclk_d;
    logic          ws_q;
    logic          chan;
    logic          synced;
    logic          left_ok;
    logic [CW-1:0] bit_cnt;
    logic [DW-1:0] shift_q;
    logic [DW-1:0] l_hold;

    logic          rise;
    logic          boundary;
    logic          sync_edge;
    logic          short_word;
    logic          shift_en;
    logic          word_done;
    logic          left_done;
    logic          emit;
    logic [DW-1:0] word_next;

    always_comb begin
        rise       = sclk & ~sclk_d;
        boundary   = rise & (lrclk != ws_q);
        // Only a right-to-left transition marks the start of a frame.
        sync_edge  = boundary & ws_q & ~lrclk;
        short_word = boundary & synced & (bit_cnt < CW'(DW));
        // Nothing is shifted until the first frame start, so a mid-frame
        // start can never yield a partial sample.
        shift_en   = rise & ~boundary & synced & (bit_cnt < CW'(DW));
        word_next  = {shift_q[DW-2:0], sdi};
        word_done  = shift_en & (bit_cnt == CW'(DW - 1));
        left_done  = word_done & ~chan;
        emit       = word_done & chan & left_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_d    <= 1'b0;
            ws_q      <= 1'b0;
            chan      <= 1'b0;
            synced    <= 1'b0;
            left_ok   <= 1'b0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            l_hold    <= '0;
            l_sample  <= '0;
            r_sample  <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
        end else begin
            sclk_d  <= sclk;
            overrun <= 1'b0;
`ifdef I2S_RX_FRAME_ERR_EN
            frame_err <= short_word;
`endif
            if (rise) begin
                ws_q <= lrclk;
            end

            if (boundary) begin
                chan <= lrclk;
                if (MSB_DELAY == 0) begin
                    // Left-justified: the bit at the boundary is already the MSB.
                    bit_cnt <= CW'(1);
                    shift_q <= {{(DW-1){1'b0}}, sdi};
                end else begin
                    bit_cnt <= '0;
                    shift_q <= '0;
                end
                if (sync_edge) begin
                    synced <= 1'b1;
                end
                // A truncated left word invalidates the pending pair.
                if (short_word && !chan) begin
                    left_ok <= 1'b0;
                end
            end else if (shift_en) begin
                shift_q <= word_next;
                bit_cnt <= bit_cnt + CW'(1);
            end

            if (left_done) begin
                l_hold  <= word_next;
                left_ok <= 1'b1;
            end

            if (emit) begin
                l_sample <= l_hold;
                r_sample <= word_next;
                valid    <= 1'b1;
                left_ok  <= 1'b0;
                overrun  <= valid & ~ready;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
